// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared definitions for the pipeline hazard controller:
//               FSM state encodings, flush_vec bit indices, stage numbering
//               and the combinational helpers used for hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    // Controller FSM state encodings
    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_DRAIN  = 2'd1;
    localparam logic [1:0] c_ST_HALTED = 2'd2;

    // flush_vec bit indices (each bit clears one pipeline register)
    localparam int c_FLUSH_IF_ID  = 0;
    localparam int c_FLUSH_ID_EX  = 1;
    localparam int c_FLUSH_EX_MEM = 2;

    // Stage numbering used by BRANCH_STAGE
    localparam int c_STAGE_IF  = 0;
    localparam int c_STAGE_ID  = 1;
    localparam int c_STAGE_EX  = 2;
    localparam int c_STAGE_MEM = 3;
    localparam int c_STAGE_WB  = 4;

    // A branch resolved in stage N has N younger wrong-path instructions
    // sitting in the N pipeline registers in front of it.
    function automatic logic [2:0] branchFlushMask(input int stage);
        logic [2:0] mask;
        mask = 3'b000;
        for (int i = 0; i < 3; i++) begin
            mask[i] = (i < stage);
        end
        return mask;
    endfunction

    // Producer/consumer register match for a load; $0 never hazards.
    function automatic logic loadMatch(
        input logic       isLoad,
        input logic [4:0] writeReg,
        input logic       usesRs,
        input logic [4:0] rs,
        input logic       usesRt,
        input logic [4:0] rt
    );
        return isLoad && (writeReg != 5'd0) &&
               ((usesRs && (writeReg == rs)) || (usesRt && (writeReg == rt)));
    endfunction

endpackage : pipeline_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter. Holds at all-ones instead of wrapping;
//               synchronous clear has priority over increment.
// Ports       : clk      - clock
//               reset    - asynchronous active-high reset
//               i_clear  - synchronous clear
//               i_en     - increment enable
//               o_count  - current count [W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush/drain controller for a 5-stage MIPS pipeline.
//               Detects load-use hazards, squashes wrong-path instructions on
//               taken branches and jumps, freezes on external stall, drains
//               the pipeline on request and keeps saturating perf counters.
// Ports       : clk, reset (async, active-high)
//               id_rs/id_rt/id_uses_rs/id_uses_rt  - ID stage source operands
//               ex_mem_read/ex_write_reg           - EX stage load producer
//               mem_mem_read/mem_write_reg         - MEM stage load producer
//               branch_taken, jump_id, ext_stall   - redirect / freeze events
//               drain_req/drain_ack                - drain handshake
//               counter_clear                      - sync clear of counters
//               pc_enable, if_id_enable, pipe_enable, flush_vec - controls
//               cycle_count, stall_count, flush_count - perf counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int BRANCH_STAGE = 3,
    parameter int LOAD_BUBBLES = 1,
    parameter int PIPE_DEPTH   = 5,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 ex_mem_read,
    input  logic [4:0]           ex_write_reg,
    input  logic                 mem_mem_read,
    input  logic [4:0]           mem_write_reg,
    input  logic                 branch_taken,
    input  logic                 jump_id,
    input  logic                 ext_stall,
    input  logic                 drain_req,
    input  logic                 counter_clear,
    output logic                 pc_enable,
    output logic                 if_id_enable,
    output logic                 pipe_enable,
    output logic [2:0]           flush_vec,
    output logic                 drain_ack,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam logic [2:0] c_BRANCH_MASK = branchFlushMask(BRANCH_STAGE);
    localparam int         c_DCNT_W      = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;
    // Last drain cycle: counter has already seen PIPE_DEPTH-2 bubbles.
    localparam logic [c_DCNT_W-1:0] c_DRAIN_LAST = c_DCNT_W'(PIPE_DEPTH - 2);

    logic [1:0]          r_state;
    logic [1:0]          w_nextState;
    logic [c_DCNT_W-1:0] r_drainCnt;
    logic                w_drainDone;
    logic                w_loadUseEx;
    logic                w_loadUseMem;
    logic                w_loadUse;
    logic                w_redirect;
    logic                w_stallCycle;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign w_loadUseEx  = loadMatch(ex_mem_read, ex_write_reg,
                                    id_uses_rs, id_rs, id_uses_rt, id_rt);
    assign w_loadUseMem = loadMatch(mem_mem_read, mem_write_reg,
                                    id_uses_rs, id_rs, id_uses_rt, id_rt);
    // Without load forwarding the consumer must also wait out the MEM stage.
    assign w_loadUse    = w_loadUseEx || ((LOAD_BUBBLES == 2) && w_loadUseMem);

    assign w_drainDone  = (r_drainCnt == c_DRAIN_LAST) && !ext_stall;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_ST_RUN: begin
                if (drain_req && !ext_stall) begin
                    w_nextState = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                // drain_req is not sampled here: once started, a drain completes.
                if (w_drainDone) begin
                    w_nextState = c_ST_HALTED;
                end
            end
            c_ST_HALTED: begin
                if (!drain_req) begin
                    w_nextState = c_ST_RUN;
                end
            end
            default: w_nextState = c_ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Drain bubble counter: advances only when the pipe actually moves
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drainCnt <= '0;
        end else if (r_state == c_ST_DRAIN) begin
            if (!ext_stall) begin
                r_drainCnt <= w_drainDone ? '0 : r_drainCnt + 1'b1;
            end
        end else begin
            r_drainCnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic (priority ext_stall > branch > load-use > jump)
    // ------------------------------------------------------------------
    always_comb begin
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        pipe_enable  = 1'b1;
        flush_vec    = 3'b000;
        drain_ack    = 1'b0;
        w_redirect   = 1'b0;
        w_stallCycle = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                if (ext_stall) begin
                    // Redirect sources re-present, so they are simply ignored.
                    pc_enable    = 1'b0;
                    if_id_enable = 1'b0;
                    pipe_enable  = 1'b0;
                    w_stallCycle = 1'b1;
                end else if (branch_taken) begin
                    // The stalled consumer is on the wrong path: no bubble.
                    flush_vec  = c_BRANCH_MASK;
                    w_redirect = 1'b1;
                end else if (w_loadUse) begin
                    pc_enable                = 1'b0;
                    if_id_enable             = 1'b0;
                    flush_vec[c_FLUSH_ID_EX] = 1'b1;
                    w_stallCycle             = 1'b1;
                end else if (jump_id) begin
                    flush_vec[c_FLUSH_IF_ID] = 1'b1;
                    w_redirect               = 1'b1;
                end
            end
            c_ST_DRAIN: begin
                if (ext_stall) begin
                    pc_enable    = 1'b0;
                    if_id_enable = 1'b0;
                    pipe_enable  = 1'b0;
                end else if (branch_taken) begin
                    // Capture the target so the pipe resumes on the right path.
                    flush_vec                = c_BRANCH_MASK;
                    flush_vec[c_FLUSH_IF_ID] = 1'b1;
                    w_redirect               = 1'b1;
                end else begin
                    pc_enable                = 1'b0;
                    flush_vec[c_FLUSH_IF_ID] = 1'b1;
                end
            end
            c_ST_HALTED: begin
                pc_enable    = 1'b0;
                if_id_enable = 1'b0;
                drain_ack    = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    sat_counter #(.W(CNT_WIDTH)) u_cycleCnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (counter_clear),
        .i_en    (1'b1),
        .o_count (cycle_count)
    );

    sat_counter #(.W(CNT_WIDTH)) u_stallCnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (counter_clear),
        .i_en    (w_stallCycle),
        .o_count (stall_count)
    );

    sat_counter #(.W(CNT_WIDTH)) u_flushCnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (counter_clear),
        .i_en    (w_redirect),
        .o_count (flush_count)
    );

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench. Two instances share stimulus:
//               A = BRANCH_STAGE 3 / LOAD_BUBBLES 1, B = BRANCH_STAGE 1 /
//               LOAD_BUBBLES 2, both with 4-bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_write_reg, mem_write_reg;
    logic       id_uses_rs, id_uses_rt, ex_mem_read, mem_mem_read;
    logic       branch_taken, jump_id, ext_stall, drain_req, counter_clear;

    logic       aPc, aIfId, aPipe, aAck, bPc, bIfId, bPipe, bAck;
    logic [2:0] aFlush, bFlush;
    logic [3:0] aCyc, aStall, aFl, bCyc, bStall, bFl;

    int nTests = 0;
    int nFail  = 0;

    // Control word {pc, if_id, pipe, flush[2:0], ack}
    localparam logic [6:0] N    = 7'b111_000_0;
    localparam logic [6:0] LU   = 7'b001_010_0;
    localparam logic [6:0] BR3  = 7'b111_111_0;
    localparam logic [6:0] BR1  = 7'b111_001_0;
    localparam logic [6:0] JMP  = 7'b111_001_0;
    localparam logic [6:0] FRZ  = 7'b000_000_0;
    localparam logic [6:0] DRN  = 7'b011_001_0;
    localparam logic [6:0] HLT  = 7'b001_000_1;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.BRANCH_STAGE(3), .LOAD_BUBBLES(1), .PIPE_DEPTH(5), .CNT_WIDTH(4)) dutA (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
        .mem_mem_read(mem_mem_read), .mem_write_reg(mem_write_reg),
        .branch_taken(branch_taken), .jump_id(jump_id), .ext_stall(ext_stall),
        .drain_req(drain_req), .counter_clear(counter_clear),
        .pc_enable(aPc), .if_id_enable(aIfId), .pipe_enable(aPipe),
        .flush_vec(aFlush), .drain_ack(aAck),
        .cycle_count(aCyc), .stall_count(aStall), .flush_count(aFl)
    );

    pipeline_hazard_ctrl #(.BRANCH_STAGE(1), .LOAD_BUBBLES(2), .PIPE_DEPTH(5), .CNT_WIDTH(4)) dutB (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
        .mem_mem_read(mem_mem_read), .mem_write_reg(mem_write_reg),
        .branch_taken(branch_taken), .jump_id(jump_id), .ext_stall(ext_stall),
        .drain_req(drain_req), .counter_clear(counter_clear),
        .pc_enable(bPc), .if_id_enable(bIfId), .pipe_enable(bPipe),
        .flush_vec(bFlush), .drain_ack(bAck),
        .cycle_count(bCyc), .stall_count(bStall), .flush_count(bFl)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic [6:0] expA, input logic [6:0] expB);
        check({tag, " A.ctl"}, {25'd0, aPc, aIfId, aPipe, aFlush, aAck}, {25'd0, expA});
        check({tag, " B.ctl"}, {25'd0, bPc, bIfId, bPipe, bFlush, bAck}, {25'd0, expB});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearHaz();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_write_reg = 5'd0;
        mem_mem_read = 1'b0; mem_write_reg = 5'd0;
        branch_taken = 1'b0; jump_id = 1'b0;
    endtask

    task automatic setLoadUse();
        ex_mem_read = 1'b1; ex_write_reg = 5'd8; id_uses_rs = 1'b1; id_rs = 5'd8;
    endtask

    initial begin
        clearHaz();
        ext_stall = 1'b0; drain_req = 1'b0; counter_clear = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        ctl("reset", N, N);
        check("reset A.cyc", 32'(aCyc), 0);
        check("reset A.stall", 32'(aStall), 0);
        check("reset A.flush", 32'(aFl), 0);

        reset = 1'b0; counter_clear = 1'b1;
        tick();
        counter_clear = 1'b0;
        check("clr A.cyc", 32'(aCyc), 0);

        // Load-use on rs from EX
        setLoadUse(); #1;
        ctl("t1 loaduse", LU, LU);
        tick();
        clearHaz(); #1;
        ctl("t1 after", N, N);
        check("t1 A.stall", 32'(aStall), 1);
        check("t1 B.stall", 32'(bStall), 1);
        check("t1 A.cyc", 32'(aCyc), 1);

        // Load in MEM on rt: only the no-forwarding variant stalls
        mem_mem_read = 1'b1; mem_write_reg = 5'd9; id_uses_rt = 1'b1; id_rt = 5'd9; #1;
        ctl("t1b memload", N, LU);
        tick();
        clearHaz(); #1;
        check("t1b A.stall", 32'(aStall), 1);
        check("t1b B.stall", 32'(bStall), 2);
        check("t1b A.cyc", 32'(aCyc), 2);

        // $0 never hazards; unused operand never hazards
        ex_mem_read = 1'b1; ex_write_reg = 5'd0; id_uses_rs = 1'b1; id_rs = 5'd0;
        mem_mem_read = 1'b1; mem_write_reg = 5'd0; id_uses_rt = 1'b1; id_rt = 5'd0; #1;
        ctl("t2 reg0", N, N);
        clearHaz();
        ex_mem_read = 1'b1; ex_write_reg = 5'd8; id_uses_rs = 1'b0; id_rs = 5'd8; #1;
        ctl("t2 unused", N, N);
        tick();
        clearHaz(); #1;
        check("t2 A.stall", 32'(aStall), 1);

        // Taken branch cancels load-use; jump; load-use beats jump
        counter_clear = 1'b1; tick(); counter_clear = 1'b0;
        setLoadUse(); branch_taken = 1'b1; #1;
        ctl("t3 branch", BR3, BR1);
        tick();
        branch_taken = 1'b0; #1;
        ctl("t3 lu resumes", LU, LU);
        clearHaz(); #1;
        check("t3 A.flush", 32'(aFl), 1);
        check("t3 B.flush", 32'(bFl), 1);
        check("t3 A.stall", 32'(aStall), 0);
        jump_id = 1'b1; #1;
        ctl("t3 jump", JMP, JMP);
        tick();
        check("t3 A.flush2", 32'(aFl), 2);
        setLoadUse(); #1;
        ctl("t3 lu>jump", LU, LU);
        clearHaz(); #1;

        // External stall beats a pending branch for 3 cycles
        counter_clear = 1'b1; tick(); counter_clear = 1'b0;
        ext_stall = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            ctl("t4 frozen", FRZ, FRZ);
            tick();
            check("t4 A.flush held", 32'(aFl), 0);
        end
        ext_stall = 1'b0; #1;
        ctl("t4 released", BR3, BR1);
        tick();
        branch_taken = 1'b0; #1;
        check("t4 A.flush", 32'(aFl), 1);
        check("t4 A.stall", 32'(aStall), 3);
        check("t4 A.cyc", 32'(aCyc), 4);

        // Drain: 4 drain cycles, then halted until drain_req drops
        drain_req = 1'b1; #1;
        ctl("t5 req run", N, N);
        tick();
        for (int i = 0; i < 4; i++) begin
            ctl("t5 drain", DRN, DRN);
            tick();
        end
        ctl("t5 halted", HLT, HLT);
        tick();
        ctl("t5 halted hold", HLT, HLT);
        drain_req = 1'b0; #1;
        ctl("t5 halted release", HLT, HLT);
        tick();
        ctl("t5 run", N, N);

        // Drain with branch, ext_stall hold, and early drain_req drop
        drain_req = 1'b1; tick();
        branch_taken = 1'b1; #1;
        ctl("t5b drain branch", BR3, BR1);
        tick();
        branch_taken = 1'b0; drain_req = 1'b0; ext_stall = 1'b1; #1;
        ctl("t5b drain frozen", FRZ, FRZ);
        tick();
        ext_stall = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            ctl("t5b drain", DRN, DRN);
            tick();
        end
        ctl("t5b halted", HLT, HLT);
        tick();
        ctl("t5b run", N, N);

        // Async reset while halted drops drain_ack without a clock edge
        drain_req = 1'b1;
        repeat (5) tick();
        ctl("t5c halted", HLT, HLT);
        #2;
        reset = 1'b1;
        #1;
        ctl("t5c async reset", N, N);
        check("t5c A.cyc", 32'(aCyc), 0);
        drain_req = 1'b0; reset = 1'b0;
        tick();

        // Saturation and clear-beats-increment
        counter_clear = 1'b1; tick(); counter_clear = 1'b0;
        setLoadUse();
        repeat (14) tick();
        check("t6 A.stall14", 32'(aStall), 14);
        repeat (6) tick();
        check("t6 A.stall sat", 32'(aStall), 15);
        check("t6 B.stall sat", 32'(bStall), 15);
        check("t6 A.cyc sat", 32'(aCyc), 15);
        counter_clear = 1'b1;
        tick();
        counter_clear = 1'b0;
        check("t6 A.cyc clr", 32'(aCyc), 0);
        check("t6 A.stall clr", 32'(aStall), 0);
        check("t6 B.flush clr", 32'(bFl), 0);
        clearHaz();
        tick();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
